// File: rtl/normshift_pipe.sv
// normshift_pipe: pipelined bidirectional barrel shifter used for normalisation.
// The log-shift levels (shift by 2^k, k ascending) are split across STAGES
// registered stages; right shifts collect the discarded bits into a sticky flag.
// Every stage carries a sideband tag through unchanged.
//
// Handshake: a transfer happens on a cycle where valid and ready are both high,
// at InValid/InReady on the input side and at OutValid/OutReady on the output
// side. A stage may load whenever it is empty or the stage after it is being
// emptied on the same edge. This readiness ripples combinationally from
// OutReady back to InReady, so a full pipe keeps streaming without bubbles.
module normshift_pipe #(
  parameter int WIDTH  = 128,
  parameter int LOGW   = $clog2(WIDTH),
  parameter int STAGES = 2,
  parameter int TAGW   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             InValid,
  output logic             InReady,
  input  logic [LOGW-1:0]  ShiftAmt,
  input  logic             Dir,
  input  logic [WIDTH-1:0] ShiftIn,
  input  logic [TAGW-1:0]  InTag,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Shifted,
  output logic             Sticky,
  output logic [TAGW-1:0]  OutTag
);

  // Shift levels per stage; level k is handled by stage k / LEVELS_PER_STAGE,
  // which leaves the remainder of the levels in the last stage.
  localparam int LEVELS_PER_STAGE = (LOGW + STAGES - 1) / STAGES;

  // Stage registers: {valid, data, full shift amount, dir, sticky, tag}.
  // The full amount is carried along; each stage uses only its own levels.
  logic [STAGES-1:0] r_valid;
  logic [WIDTH-1:0]  r_data   [STAGES];
  logic [LOGW-1:0]   r_amt    [STAGES];
  logic              r_dir    [STAGES];
  logic              r_sticky [STAGES];
  logic [TAGW-1:0]   r_tag    [STAGES];

  // Per-stage inputs: stage 0 reads the ports, stage s reads register s-1.
  logic [STAGES-1:0] w_in_valid;
  logic [WIDTH-1:0]  w_in_data   [STAGES];
  logic [LOGW-1:0]   w_in_amt    [STAGES];
  logic              w_in_dir    [STAGES];
  logic              w_in_sticky [STAGES];
  logic [TAGW-1:0]   w_in_tag    [STAGES];

  // Per-stage shifted data and sticky before the stage register.
  logic [WIDTH-1:0]  w_nxt_data   [STAGES];
  logic              w_nxt_sticky [STAGES];

  // Per-stage load enable.
  logic [STAGES-1:0] w_ready;

  // Route the input ports and earlier stage registers to each stage's input.
  always_comb begin
    w_in_valid[0]  = InValid;
    w_in_data[0]   = ShiftIn;
    w_in_amt[0]    = ShiftAmt;
    w_in_dir[0]    = Dir;
    w_in_sticky[0] = 1'b0;
    w_in_tag[0]    = InTag;
    for (int s = 1; s < STAGES; s++) begin
      w_in_valid[s]  = r_valid[s-1];
      w_in_data[s]   = r_data[s-1];
      w_in_amt[s]    = r_amt[s-1];
      w_in_dir[s]    = r_dir[s-1];
      w_in_sticky[s] = r_sticky[s-1];
      w_in_tag[s]    = r_tag[s-1];
    end
  end

  // Readiness ripple from the output back to stage 0: a stage can load when
  // it is empty or everything downstream of it is moving.
  always_comb begin
    logic acc;
    acc     = OutReady;
    w_ready = '0;
    for (int s = STAGES - 1; s >= 0; s--) begin
      acc        = !r_valid[s] | acc;
      w_ready[s] = acc;
    end
  end

  // Shift levels owned by each stage. Right shifts OR the bits that fall off
  // the LSB end into the sticky flag. Every level shifts by less than WIDTH,
  // so an over-range amount simply drains the operand to zero and leaves all
  // of its ones in sticky.
  always_comb begin
    logic [WIDTH-1:0] d_acc;
    logic             st_acc;
    d_acc  = '0;
    st_acc = 1'b0;
    for (int s = 0; s < STAGES; s++) begin
      d_acc  = w_in_data[s];
      st_acc = w_in_sticky[s];
      for (int k = 0; k < LOGW; k++) begin
        if (((k / LEVELS_PER_STAGE) == s) && w_in_amt[s][k]) begin
          if (w_in_dir[s]) begin
            st_acc = st_acc | (|(d_acc << (WIDTH - (1 << k))));
            d_acc  = d_acc >> (1 << k);
          end else begin
            d_acc  = d_acc << (1 << k);
          end
        end
      end
      w_nxt_data[s]   = d_acc;
      w_nxt_sticky[s] = st_acc;
    end
  end

  // Stage registers. The payload loads only with a valid operation, so the
  // outputs hold steady while the result waits under backpressure. Flush
  // drops every valid bit (and the operation presented that cycle); reset
  // takes priority and clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      for (int s = 0; s < STAGES; s++) begin
        r_data[s]   <= '0;
        r_amt[s]    <= '0;
        r_dir[s]    <= 1'b0;
        r_sticky[s] <= 1'b0;
        r_tag[s]    <= '0;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (w_ready[s] && w_in_valid[s]) begin
          r_data[s]   <= w_nxt_data[s];
          r_amt[s]    <= w_in_amt[s];
          r_dir[s]    <= w_in_dir[s];
          r_sticky[s] <= w_nxt_sticky[s];
          r_tag[s]    <= w_in_tag[s];
        end
        if (flush) begin
          r_valid[s] <= 1'b0;
        end else if (w_ready[s]) begin
          r_valid[s] <= w_in_valid[s];
        end
      end
    end
  end

  assign InReady  = w_ready[0];
  assign OutValid = r_valid[STAGES-1];
  assign Shifted  = r_data[STAGES-1];
  assign Sticky   = r_sticky[STAGES-1];
  assign OutTag   = r_tag[STAGES-1];

endmodule

// File: tb/tb_normshift_pipe.sv
// tb_normshift_pipe: directed and random checks of normshift_pipe (16 bits, 2 stages).
module tb_normshift_pipe;

  localparam int W      = 16;
  localparam int LW     = 4;
  localparam int STAGES = 2;
  localparam int TW     = 4;
  localparam int EW     = W + 1 + TW;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          InValid;
  logic          InReady;
  logic [LW-1:0] ShiftAmt;
  logic          Dir;
  logic [W-1:0]  ShiftIn;
  logic [TW-1:0] InTag;
  logic          OutValid;
  logic          OutReady;
  logic [W-1:0]  Shifted;
  logic          Sticky;
  logic [TW-1:0] OutTag;

  int n_tests = 0;
  int n_fail  = 0;

  logic [EW-1:0] exp_q[$];
  logic [TW-1:0] tag_log[$];

  normshift_pipe #(.WIDTH(W), .STAGES(STAGES), .TAGW(TW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .InValid(InValid), .InReady(InReady),
    .ShiftAmt(ShiftAmt), .Dir(Dir), .ShiftIn(ShiftIn), .InTag(InTag),
    .OutValid(OutValid), .OutReady(OutReady),
    .Shifted(Shifted), .Sticky(Sticky), .OutTag(OutTag)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Returns {shifted, sticky} from plain arithmetic.
  function automatic logic [W:0] model(input logic [W-1:0] d, input logic [LW-1:0] amt,
                                       input logic dir);
    logic [W-1:0] res;
    logic [W:0]   mask;
    logic         st;
    if (!dir) begin
      res = d << amt;
      st  = 1'b0;
    end else begin
      res  = d >> amt;
      mask = (17'd1 << amt) - 17'd1;
      st   = |({1'b0, d} & mask);
    end
    return {res, st};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- scoreboard / compare process ----------------
  // Sampled on the falling edge: decides what the coming rising edge transfers.
  always @(negedge clk) begin
    logic exp_rdy;
    logic [EW-1:0] got;
    if (reset) begin
      exp_q.delete();
    end else begin
      // With no bubbles the pipe refuses input only when it holds STAGES
      // operations and the consumer is stalled.
      exp_rdy = (exp_q.size() < STAGES) || OutReady;
      n_tests++;
      if (InReady !== exp_rdy) begin
        n_fail++;
        $display("FAIL in_ready: got %0b expected %0b (occupancy %0d)", InReady, exp_rdy,
                 exp_q.size());
      end
      if (OutValid === 1'b1) begin
        got = {Shifted, Sticky, OutTag};
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL spurious_out: got %0h expected no result", got);
        end else begin
          if (got !== exp_q[0]) begin
            n_fail++;
            $display("FAIL result: got %0h expected %0h", got, exp_q[0]);
          end
          if (OutReady && !flush) begin
            void'(exp_q.pop_front());
            tag_log.push_back(OutTag);
          end
        end
      end
      if (flush) exp_q.delete();
      else if (InValid && InReady) exp_q.push_back({model(ShiftIn, ShiftAmt, Dir), InTag});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_op(input logic [LW-1:0] amt, input logic dir, input logic [W-1:0] d,
                        input logic [TW-1:0] tag);
    ShiftAmt = amt;
    Dir      = dir;
    ShiftIn  = d;
    InTag    = tag;
  endtask

  // Presents one operation until accepted; returns just after the accepting edge.
  task automatic push_op(input logic [LW-1:0] amt, input logic dir, input logic [W-1:0] d,
                         input logic [TW-1:0] tag);
    logic acc;
    set_op(amt, dir, d, tag);
    InValid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = InReady;
      @(posedge clk); #1;
    end
    InValid = 1'b0;
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL push_timeout: got not accepted expected accepted");
    end
  endtask

  // Waits for OutValid after an accept; lat counts rising edges including the accepting one.
  task automatic wait_out(output int lat);
    logic seen;
    lat = 1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (OutValid === 1'b1) seen = 1'b1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL out_timeout: got no OutValid expected OutValid");
    end
  endtask

  // One directed op: check latency and literal result at the output.
  task automatic direct_op(input string name, input logic [LW-1:0] amt, input logic dir,
                           input logic [W-1:0] d, input logic [TW-1:0] tag,
                           input logic [W-1:0] e_d, input logic e_st);
    int lat;
    push_op(amt, dir, d, tag);
    wait_out(lat);
    chk({name, "_latency"}, lat, STAGES);
    chk({name, "_shifted"}, Shifted, e_d);
    chk({name, "_sticky"}, Sticky, e_st);
    chk({name, "_tag"}, OutTag, tag);
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0]  bp_data [4] = '{16'h1234, 16'h8001, 16'h00F0, 16'hFFFF};
  logic [LW-1:0] bp_amt  [4] = '{4'd1, 4'd1, 4'd4, 4'd8};
  logic          bp_dir  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    int n_acc;
    int cyc;
    logic acc;

    reset = 1'b1; flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
    set_op('0, 1'b0, '0, '0);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outvalid", OutValid, 0);
    chk("reset_shifted", Shifted, 0);
    chk("reset_sticky", Sticky, 0);
    chk("reset_outtag", OutTag, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_inready", InReady, 1);
    @(posedge clk); #1;

    // Left and right directed shifts
    direct_op("left15", 4'd15, 1'b0, 16'h0001, 4'd3, 16'h8000, 1'b0);
    direct_op("right_lost", 4'd4, 1'b1, 16'h00FF, 4'd5, 16'h000F, 1'b1);
    direct_op("right_clean", 4'd4, 1'b1, 16'h00F0, 4'd6, 16'h000F, 1'b0);
    direct_op("right_zero", 4'd0, 1'b1, 16'hFFFF, 4'd7, 16'hFFFF, 1'b0);
    direct_op("left_drop", 4'd8, 1'b0, 16'hABCD, 4'd8, 16'hCD00, 1'b0);
    direct_op("right_max", 4'd15, 1'b1, 16'h8001, 4'd9, 16'h0001, 1'b1);

    // Backpressure: four ops, consumer stalled for four cycles
    tag_log.delete();
    OutReady = 1'b0;
    n_acc = 0;
    for (int c = 0; c < 4; c++) begin
      set_op(bp_amt[n_acc], bp_dir[n_acc], bp_data[n_acc], TW'(n_acc));
      InValid = 1'b1;
      @(negedge clk);
      acc = InReady;
      @(posedge clk); #1;
      if (acc) n_acc++;
    end
    chk("bp_accepted_while_stalled", n_acc, 2);
    @(negedge clk);
    chk("bp_inready_low", InReady, 0);
    @(posedge clk); #1;
    OutReady = 1'b1;
    cyc = 0;
    while (n_acc < 4 && cyc < 20) begin
      set_op(bp_amt[n_acc], bp_dir[n_acc], bp_data[n_acc], TW'(n_acc));
      InValid = 1'b1;
      @(negedge clk);
      acc = InReady;
      @(posedge clk); #1;
      if (acc) n_acc++;
      cyc++;
    end
    InValid = 1'b0;
    cyc = 0;
    while (tag_log.size() < 4 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("bp_result_count", tag_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < tag_log.size()) chk("bp_tag_order", tag_log[i], i);
    end
    repeat (3) @(posedge clk); #1;
    chk("bp_no_duplicates", tag_log.size(), 4);

    // Flush with two in flight and a third presented
    tag_log.delete();
    OutReady = 1'b0;
    push_op(4'd2, 1'b0, 16'h0F0F, 4'd1);
    push_op(4'd3, 1'b1, 16'hF0F7, 4'd2);
    set_op(4'd1, 1'b0, 16'h0001, 4'd3);
    InValid = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    InValid = 1'b0;
    @(negedge clk);
    chk("flush_outvalid", OutValid, 0);
    @(posedge clk); #1;
    OutReady = 1'b1;
    repeat (5) @(posedge clk); #1;
    chk("flush_no_results", tag_log.size(), 0);
    direct_op("after_flush", 4'd3, 1'b1, 16'h0009, 4'd10, 16'h0001, 1'b1);

    // Reset mid-stream
    OutReady = 1'b1;
    set_op(4'd1, 1'b1, 16'h0003, 4'd11);
    InValid = 1'b1;
    @(posedge clk); #1;
    set_op(4'd2, 1'b1, 16'h0007, 4'd12);
    @(posedge clk); #1;
    set_op(4'd5, 1'b1, 16'hFFFF, 4'd13);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    InValid = 1'b0;
    @(negedge clk);
    chk("midreset_outvalid", OutValid, 0);
    chk("midreset_shifted", Shifted, 0);
    chk("midreset_sticky", Sticky, 0);
    chk("midreset_outtag", OutTag, 0);
    chk("midreset_inready", InReady, 1);
    @(posedge clk); #1;

    // Random traffic with random backpressure
    n_acc = 0;
    cyc = 0;
    while (n_acc < 10000 && cyc < 60000) begin
      case ($urandom_range(0, 3))
        0: ShiftIn = 16'hFFFF;
        1: ShiftIn = 16'h0001 << $urandom_range(0, 15);
        default: ShiftIn = W'($urandom);
      endcase
      ShiftAmt = LW'($urandom_range(0, 15));
      Dir      = 1'($urandom_range(0, 1));
      InTag    = TW'($urandom_range(0, 15));
      InValid  = ($urandom_range(0, 3) != 0);
      OutReady = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = InValid && InReady;
      @(posedge clk); #1;
      if (acc) n_acc++;
      cyc++;
    end
    chk("random_ops_accepted", n_acc, 10000);
    InValid = 1'b0;
    OutReady = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("random_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
